// File: rtl/mca_sequencer_pkg.sv
// Shared types and helpers for the multi-clock adder tree sequencer.
package mca_sequencer_pkg;

    typedef enum logic [1:0] {SEQ_FILL, SEQ_IDLE, SEQ_RUN, SEQ_CAPTURE} mca_seq_state_t;

    // Start pulse to valid tree result, in cycles.
    function automatic int mca_tree_latency(input int num_additions);
        return 2 * num_additions + 2;
    endfunction

endpackage

// File: rtl/mca_seq_window.sv
// K-bit control-bit shift register with saturating fill count and frozen snapshot.
module mca_seq_window #(
    parameter int K = 256
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         shift_en,
    input  logic         bit_in,
    input  logic         capture,
    output logic         full,
    output logic [K-1:0] window
);
    localparam int FW = $clog2(K + 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(K);
    localparam logic [FW-1:0] FILL_LAST = FW'(K - 1);

    logic [K-1:0]  shreg;
    logic [K-1:0]  shreg_next;
    logic [FW-1:0] fill_cnt;

    assign shreg_next = shift_en ? {shreg[K-2:0], bit_in} : shreg;

    // Full counts the bit being shifted in this cycle, so the K-th bit can trigger.
    assign full = (fill_cnt == FILL_MAX) || (shift_en && (fill_cnt == FILL_LAST));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg    <= '0;
            fill_cnt <= '0;
            window   <= '0;
        end else begin
            shreg <= shreg_next;
            if (shift_en && (fill_cnt != FILL_MAX))
                fill_cnt <= fill_cnt + FW'(1);
            if (capture)
                window <= shreg_next;
        end
    end

endmodule

// File: rtl/mca_sequencer.sv
// Sequencer for the multi-clock adder tree: windowing, OSR decimation,
// tree launch/latency tracking and a valid/ready result register.
module mca_sequencer
    import mca_sequencer_pkg::*;
#(
    parameter int K                 = 256,
    parameter int OSR               = 16,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int MCA_NUM_ADDITIONS = 16,
    parameter int TREE_LATENCY      = mca_tree_latency(MCA_NUM_ADDITIONS)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         s_valid,
    input  logic                         s_bit,
    output logic [K-1:0]                 s_window,
    output logic                         tree_start,
    input  logic [WIDTH_COEFFICIENT-1:0] tree_result,
    output logic [WIDTH_COEFFICIENT-1:0] sample_out,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic                         busy,
    output logic                         overrun,
    output logic                         overwrite,
    input  logic                         clear_flags
);
    localparam int DSW = $clog2(OSR);
    localparam int LW  = $clog2(TREE_LATENCY);
    localparam logic [DSW-1:0] DS_LAST  = DSW'(OSR - 1);
    localparam logic [LW-1:0]  LAT_LAST = LW'(TREE_LATENCY - 1);

    mca_seq_state_t state, state_next;
    logic [DSW-1:0] ds_cnt;
    logic [LW-1:0]  lat_cnt;
    logic           window_full;
    logic           trigger;
    logic           launch;
    logic           capture;
    logic           overrun_set;
    logic           overwrite_set;

    assign trigger       = s_valid && (ds_cnt == DS_LAST) && window_full;
    assign launch        = trigger && ((state == SEQ_FILL) || (state == SEQ_IDLE));
    assign capture       = (state == SEQ_CAPTURE);
    // The tree is still owned through CAPTURE, so a trigger there is lost too.
    assign overrun_set   = trigger && !launch;
    assign overwrite_set = capture && sample_valid && !sample_ready;

    mca_seq_window #(.K(K)) u_window (
        .clk      (clk),
        .resetn   (resetn),
        .shift_en (s_valid),
        .bit_in   (s_bit),
        .capture  (launch),
        .full     (window_full),
        .window   (s_window)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= SEQ_FILL;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SEQ_FILL: begin
                if (launch)           state_next = SEQ_RUN;
                else if (window_full) state_next = SEQ_IDLE;
            end
            SEQ_IDLE:    if (launch) state_next = SEQ_RUN;
            SEQ_RUN:     if (lat_cnt == LAT_LAST) state_next = SEQ_CAPTURE;
            SEQ_CAPTURE: state_next = SEQ_IDLE;
            default:     state_next = SEQ_FILL;
        endcase
    end

    // lat_cnt is zero only on the first RUN cycle, which makes the start pulse one cycle wide.
    always_comb begin
        busy       = 1'b0;
        tree_start = 1'b0;
        if (state == SEQ_RUN) begin
            busy       = 1'b1;
            tree_start = (lat_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ds_cnt       <= '0;
            lat_cnt      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            overwrite    <= 1'b0;
        end else begin
            if (s_valid)
                ds_cnt <= (ds_cnt == DS_LAST) ? '0 : ds_cnt + DSW'(1);

            if (launch)
                lat_cnt <= '0;
            else if (state == SEQ_RUN)
                lat_cnt <= lat_cnt + LW'(1);

            // A capture always wins over a same-cycle handshake.
            if (capture) begin
                sample_out   <= tree_result;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (overrun_set)      overrun <= 1'b1;
            else if (clear_flags) overrun <= 1'b0;

            if (overwrite_set)    overwrite <= 1'b1;
            else if (clear_flags) overwrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mca_sequencer.sv
// Self-checking bench for mca_sequencer: directed table, corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_mca_sequencer;
    localparam int K   = 16;
    localparam int OSR = 8;
    localparam int W   = 32;
    localparam int NA  = 16;
    localparam int TL  = 2 * NA + 2;

    logic           clk = 1'b0;
    logic           resetn = 1'b0, s_valid = 1'b0, s_bit = 1'b0;
    logic           sample_ready = 1'b0, clear_flags = 1'b0;
    logic [W-1:0]   tree_result = '0;
    logic [K-1:0]   s_window;
    logic           tree_start, sample_valid, busy, overrun, overwrite;
    logic [W-1:0]   sample_out;

    mca_sequencer #(.K(K), .OSR(OSR), .WIDTH_COEFFICIENT(W), .MCA_NUM_ADDITIONS(NA)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_valid      (s_valid),
        .s_bit        (s_bit),
        .s_window     (s_window),
        .tree_start   (tree_start),
        .tree_result  (tree_result),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun),
        .overwrite    (overwrite),
        .clear_flags  (clear_flags)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: bits accepted since reset, launch timestamp, result register.
    logic [K-1:0] m_win = '0, m_snap = '0;
    logic [W-1:0] m_sout = '0;
    int m_nbits = 0, m_L = 0, m_edge = 0, m_caps = 0;
    bit m_active = 0, m_sv = 0, m_ovr = 0, m_ow = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_edge);
        end
    endtask

    task automatic model_edge();
        bit cap, trig, free, ovr_set, ow_set;
        m_edge++;
        if (!resetn) begin
            m_win = '0; m_snap = '0; m_nbits = 0; m_active = 0; m_L = 0;
            m_sv = 0; m_sout = '0; m_ovr = 0; m_ow = 0;
        end else begin
            cap  = m_active && (m_edge == m_L + TL + 1);
            trig = s_valid && ((m_nbits + 1) % OSR == 0) && (m_nbits + 1 >= K);
            free = !m_active || (m_edge >= m_L + TL + 2);
            if (s_valid) begin
                m_win = {m_win[K-2:0], s_bit};
                m_nbits++;
            end
            ovr_set = 0;
            ow_set  = 0;
            if (trig) begin
                if (free) begin m_L = m_edge; m_active = 1; m_snap = m_win; end
                else ovr_set = 1;
            end
            if (cap) begin
                ow_set = m_sv && !sample_ready;
                m_sout = tree_result;
                m_sv   = 1;
                m_caps++;
            end else if (m_sv && sample_ready) begin
                m_sv = 0;
            end
            m_ovr = ovr_set || (m_ovr && !clear_flags);
            m_ow  = ow_set  || (m_ow  && !clear_flags);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic b, input logic rdy,
                        input logic clr, input logic [W-1:0] tr);
        resetn = rst; s_valid = v; s_bit = b; sample_ready = rdy; clear_flags = clr; tree_result = tr;
        @(posedge clk);
        model_edge();
        #1;
        chk("tree_start",   tree_start,   m_active && (m_edge == m_L));
        chk("busy",         busy,         m_active && (m_edge >= m_L) && (m_edge < m_L + TL));
        chk("s_window",     s_window,     m_snap);
        chk("sample_valid", sample_valid, m_sv);
        chk("sample_out",   sample_out,   m_sout);
        chk("overrun",      overrun,      m_ovr);
        chk("overwrite",    overwrite,    m_ow);
    endtask

    typedef struct {
        logic rst, v, b, rdy, clr;
        logic exp_start, exp_busy, exp_ovr;
        logic [K-1:0] exp_win;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, input logic v, input logic b, input logic rdy, input logic clr,
                       input logic es, input logic eb, input logic eo, input logic [K-1:0] ew);
        vec_t e;
        e.rst = rst; e.v = v; e.b = b; e.rdy = rdy; e.clr = clr;
        e.exp_start = es; e.exp_busy = eb; e.exp_ovr = eo; e.exp_win = ew;
        tbl.push_back(e);
    endtask

    initial begin
        logic [K-1:0] pat;
        bit ts[300], bz[300], sv[300];
        int st0, st1, r0, nbusy, caps0, cb, seen;
        logic [W-1:0] tr, last_cap;
        bit done;

        // Fill, first launch on the 16th bit, then an overrun 8 bits later while RUN.
        pat = 16'hA5C3;
        add(0, 0, 0, 1, 0, 0, 0, 0, '0);
        add(0, 0, 0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 16; i++)
            add(1, 1, pat[15-i], 1, 0, i == 15, i == 15, 0, (i == 15) ? pat : '0);
        for (int j = 0; j < 8; j++)
            add(1, 1, 1, 1, 0, 0, 1, j == 7, pat);
        add(1, 0, 0, 1, 1, 0, 1, 0, pat);
        add(1, 0, 0, 1, 0, 0, 1, 0, pat);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].rdy, tbl[i].clr, 32'h0000_1234);
            chk("tbl_start",   tree_start, tbl[i].exp_start);
            chk("tbl_busy",    busy,       tbl[i].exp_busy);
            chk("tbl_overrun", overrun,    tbl[i].exp_ovr);
            chk("tbl_window",  s_window,   tbl[i].exp_win);
        end

        // Gapped input, one bit every 5 cycles: launches 40 cycles apart, no overrun.
        step(0, 0, 0, 1, 0, 32'h0000_1234);
        for (int c = 0; c < 300; c++) begin
            step(1, (c % 5) == 0, 1'($urandom), 1, 0, 32'h0000_1234);
            ts[c] = tree_start; bz[c] = busy; sv[c] = sample_valid;
        end
        st0 = -1; st1 = -1; r0 = -1;
        for (int c = 0; c < 300; c++) begin
            if (ts[c] && st0 < 0) st0 = c;
            else if (ts[c] && st1 < 0) st1 = c;
            if (st0 >= 0 && r0 < 0 && c > 0 && sv[c] && !sv[c-1]) r0 = c;
        end
        chk("gap_first_start", st0, 75);
        chk("gap_start_interval", st1 - st0, 40);
        chk("start_to_valid", r0 - st0, TL + 1);
        nbusy = 0;
        if (st0 >= 0 && r0 > st0)
            for (int c = st0; c < r0; c++) nbusy += int'(bz[c]);
        chk("busy_cycles", nbusy, TL);
        chk("gap_overrun", overrun, 0);

        // Backpressure across two captures: second value wins, overwrite flagged.
        caps0 = m_caps; last_cap = '0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            tr = 32'hC0DE_0000 | W'(c);
            cb = m_caps;
            step(1, (c % 5) == 0, 1'($urandom), 0, 0, tr);
            if (m_caps != cb) last_cap = tr;
            done = (m_caps >= caps0 + 2);
        end
        if (!done) chk("bp_timeout", 0, 1);
        chk("bp_overwrite", overwrite, 1);
        chk("bp_valid", sample_valid, 1);
        chk("bp_value", sample_out, last_cap);
        step(1, 0, 0, 1, 0, 32'h0);
        chk("bp_handshake_valid", sample_valid, 0);
        chk("bp_overwrite_held", overwrite, 1);
        step(1, 0, 0, 0, 1, 32'h0);
        chk("bp_clear", overwrite, 0);

        // Reset at lat_cnt==10: everything drops; the next start needs K fresh bits.
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            step(1, (c % 5) == 0, 1'($urandom), 1, 0, 32'h0000_5678);
            done = m_active && (m_edge == m_L);
        end
        if (!done) chk("rst_wait_timeout", 0, 1);
        for (int c = 0; c < 10; c++) step(1, 0, 0, 1, 0, 32'h0000_5678);
        step(0, 0, 0, 1, 0, 32'h0000_5678);
        chk("rst_busy", busy, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_start", tree_start, 0);
        chk("rst_window", s_window, 0);
        chk("rst_flags", {overrun, overwrite}, 0);
        seen = 0;
        for (int c = 0; c < 15 + TL + 2; c++) begin
            step(1, c < 15, 1'($urandom), 1, 0, 32'h0000_5678);
            seen += int'(tree_start) + int'(sample_valid) + int'(busy);
        end
        chk("rst_no_activity", seen, 0);
        step(1, 1, 1, 1, 0, 32'h0000_5678);
        chk("rst_restart", tree_start, 1);

        // Randomized traffic with varying input density, backpressure, clears and resets.
        for (int seg = 0; seg < 8; seg++) begin
            int dens;
            dens = $urandom_range(1, 4);
            for (int c = 0; c < 500; c++)
                step(($urandom_range(0, 999) != 0), ($urandom_range(0, 3) < dens), 1'($urandom),
                     1'($urandom), ($urandom_range(0, 19) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
